// File: rtl/fg_config_loader_pkg.sv
// Shared definitions for the function-generator config loader: command byte
// layout, FSM state encoding and the field map of the 64-bit config word.
package fg_config_pkg;

  // Command byte layout: W = write data phase, C = commit shadow to active
  localparam int CMD_W_BIT  = 7;
  localparam int CMD_C_BIT  = 6;
  localparam int CMD_IDX_HI = 4;
  localparam int CMD_IDX_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } fg_state_e;

  // Field positions inside the active config word seen by the generator
  localparam int CR_CS_MODE_BIT = 63;
  localparam int CR_MS_MODE_BIT = 62;
  localparam int CR_RADIX_BIT   = 61;
  localparam int CR_PSC_HI      = 60;
  localparam int CR_PSC_LO      = 52;
  localparam int CR_CNT_HI      = 51;
  localparam int CR_CNT_LO      = 42;
  localparam int CR_PHASE_HI    = 41;
  localparam int CR_PHASE_LO    = 32;
  localparam int CR_K_RISE_HI   = 31;
  localparam int CR_K_RISE_LO   = 24;
  localparam int CR_K_FALL_HI   = 23;
  localparam int CR_K_FALL_LO   = 16;
  localparam int CR_AMP_HI      = 15;
  localparam int CR_AMP_LO      = 8;
  localparam int CR_OFFSET_HI   = 7;
  localparam int CR_OFFSET_LO   = 0;

  // A command with C set and W clear commits without a data phase
  function automatic logic is_commit_only(input logic [7:0] cmd);
    return !cmd[CMD_W_BIT] && cmd[CMD_C_BIT];
  endfunction

endpackage

// File: rtl/fg_config_loader_if.sv
// Serial config port bundle (SPI mode 0, MSB first).
// Protocol: the host owns sclk_i/cs_n_i/mosi_i; a frame spans cs_n_i low,
// mosi_i is sampled on sclk_i rising edges and miso_o changes after falling
// edges. There is no valid/ready pair: flow is paced purely by sclk_i.
interface fg_config_loader_if;
  logic sclk_i;
  logic cs_n_i;
  logic mosi_i;
  logic miso_o;

  modport master (output sclk_i, output cs_n_i, output mosi_i, input miso_o);
  modport slave  (input sclk_i, input cs_n_i, input mosi_i, output miso_o);
endinterface

// File: rtl/fg_config_loader_sync_edge.sv
// N-flop synchronizer for one asynchronous input plus rise/fall detection in
// the clk_i domain. All flops clear to 0, so a line that is already low when
// reset is released never produces a spurious falling edge.
module fg_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the async input through the chain and remember the last synced level
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/fg_config_loader.sv
// Serial loader for the function-generator config word. Bytes land in a
// shadow register; the active word CR_bus_o only changes on a commit, so the
// generator never sees a half-written configuration.
module fg_config_loader
  import fg_config_pkg::*;
#(
  parameter int                             CONFIG_REG_BITWIDTH = 64,
  parameter int                             SYNC_STAGES         = 2,
  parameter logic [CONFIG_REG_BITWIDTH-1:0] RESET_VALUE         = '0
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  fg_config_loader_if.slave              spi,
  output logic [CONFIG_REG_BITWIDTH-1:0] CR_bus_o,
  output logic                           configUpdate_STRB_o,
  output logic                           frameActive_o,
  output logic [1:0]                     state_o
);

  localparam int NBYTES = CONFIG_REG_BITWIDTH / 8;

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  fg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(spi.sclk_i),
    .q_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));

  fg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(spi.cs_n_i),
    .q_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall));

  fg_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_i(clk_i), .rstn_i(rstn_i), .d_i(spi.mosi_i),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

  fg_state_e                     state_q;
  logic [2:0]                    bit_cnt_q;
  logic [7:0]                    shift_q;
  logic                          cmd_w_q, cmd_c_q;
  logic [4:0]                    cmd_idx_q;
  logic [CONFIG_REG_BITWIDTH-1:0] shadow_q, cr_q;
  logic                          strobe_q, miso_q;
  logic [6:0]                    miso_sr_q;

  logic [7:0]                    shift_d;
  logic [CONFIG_REG_BITWIDTH-1:0] shadow_d;
  logic [7:0]                    rd_byte;

  // Byte being completed by this rise, shadow with that byte merged in, and
  // the active byte addressed by a command completing now (0 if out of range)
  always_comb begin
    shift_d  = {shift_q[6:0], mosi_s};
    shadow_d = shadow_q;
    rd_byte  = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (cmd_idx_q == 5'(k)) shadow_d[k*8 +: 8] = shift_d;
      if (shift_d[CMD_IDX_HI:CMD_IDX_LO] == 5'(k)) rd_byte = cr_q[k*8 +: 8];
    end
  end

  // Frame FSM with shift register, bit counter, shadow/active words and miso
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      cmd_w_q   <= 1'b0;
      cmd_c_q   <= 1'b0;
      cmd_idx_q <= 5'd0;
      shadow_q  <= RESET_VALUE;
      cr_q      <= RESET_VALUE;
      strobe_q  <= 1'b0;
      miso_q    <= 1'b0;
      miso_sr_q <= 7'd0;
    end else begin
      strobe_q <= 1'b0;
      if (cs_rise) begin
        // End of frame or abort: anything not yet completed is dropped
        state_q   <= ST_IDLE;
        bit_cnt_q <= 3'd0;
        miso_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cs_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= 3'd0;
            end
          end
          ST_CMD: begin
            if (sclk_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                cmd_w_q   <= shift_d[CMD_W_BIT];
                cmd_c_q   <= shift_d[CMD_C_BIT];
                cmd_idx_q <= shift_d[CMD_IDX_HI:CMD_IDX_LO];
                if (is_commit_only(shift_d)) begin
                  cr_q     <= shadow_q;
                  strobe_q <= 1'b1;
                  state_q  <= ST_DONE;
                end else begin
                  state_q <= ST_DATA;
                  if (!shift_d[CMD_W_BIT]) begin
                    miso_q    <= rd_byte[7];
                    miso_sr_q <= rd_byte[6:0];
                  end
                end
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= ST_DONE;
                if (cmd_w_q) begin
                  shadow_q <= shadow_d;
                  if (cmd_c_q) begin
                    cr_q     <= shadow_d;
                    strobe_q <= 1'b1;
                  end
                end else begin
                  miso_q <= 1'b0;
                end
              end
            end else if (sclk_fall && !cmd_w_q && bit_cnt_q != 3'd0) begin
              // bit7 is already on miso; falls after each sampled bit advance
              miso_q    <= miso_sr_q[6];
              miso_sr_q <= {miso_sr_q[5:0], 1'b0};
            end
          end
          ST_DONE: begin
            // One command per frame: further clocks are ignored
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign CR_bus_o            = cr_q;
  assign configUpdate_STRB_o = strobe_q;
  assign frameActive_o       = (state_q != ST_IDLE);
  assign state_o             = state_q;
  assign spi.miso_o          = miso_q;

endmodule

// File: tb/tb_fg_config_loader.sv
// Bench for fg_config_loader: frame-level host model with a per-cycle
// scoreboard, plus hand-computed literal checks after each scenario.
`timescale 1ns/1ps
module tb_fg_config_loader;

  localparam int W = 64;
  localparam int LAT = 3;  // input change at negedge k -> output update at posedge k+3

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] cr;
  logic         strb, fa;
  logic [1:0]   st;

  fg_config_loader_if spi_if();

  fg_config_loader #(
    .CONFIG_REG_BITWIDTH(W), .SYNC_STAGES(2), .RESET_VALUE({W{1'b0}})
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .spi(spi_if),
    .CR_bus_o(cr), .configUpdate_STRB_o(strb),
    .frameActive_o(fa), .state_o(st)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / checker ----------------
  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int strb_seen = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int unsigned  at;
    logic [W-1:0] cr;
    logic         strb;
    logic         miso;
    logic         fa;
  } ev_t;

  ev_t          ev_q[$];
  logic [W-1:0] exp_q[$];   // expected active word after each commit, in order
  logic [W-1:0] m_shadow, m_cr;
  logic         m_miso, m_fa;
  logic [W-1:0] cur_cr;
  logic         cur_miso, cur_fa;

  task automatic push(input logic s);
    ev_t e;
    e.at = cyc + LAT; e.cr = m_cr; e.strb = s; e.miso = m_miso; e.fa = m_fa;
    ev_q.push_back(e);
    if (s) exp_q.push_back(m_cr);
  endtask

  task automatic model_reset();
    m_shadow = '0; m_cr = '0; m_miso = 1'b0; m_fa = 1'b0;
    ev_q.delete();
    cur_cr = '0; cur_miso = 1'b0; cur_fa = 1'b0;
  endtask

  // ---------------- per-cycle compare ----------------
  always begin
    logic exp_strb;
    ev_t  e;
    @(posedge clk);
    cyc++;
    #3;
    exp_strb = 1'b0;
    while (ev_q.size() > 0 && ev_q[0].at <= cyc) begin
      e = ev_q.pop_front();
      cur_cr = e.cr; cur_miso = e.miso; cur_fa = e.fa;
      exp_strb = e.strb;
    end
    chk("cr_bus", cr, cur_cr);
    chk("strobe", W'(strb), W'(exp_strb));
    chk("miso", W'(spi_if.miso_o), W'(cur_miso));
    chk("frame_active", W'(fa), W'(cur_fa));
    if (strb) begin
      strb_seen++;
      if (exp_q.size() > 0) chk("commit_word", cr, exp_q.pop_front());
    end
  end

  // ---------------- driver ----------------
  task automatic half();
    repeat (3) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [7:0] data,
                       input int cmd_bits, input int data_bits, input bit rst_mid,
                       output logic [7:0] rd);
    logic       w, c, phase_data;
    int         idx;
    logic [7:0] rbyte;
    w = cmd[7]; c = cmd[6]; idx = int'(cmd[4:0]);
    rd = 8'h00; rbyte = 8'h00; phase_data = 1'b0;
    // frame start
    @(negedge clk);
    spi_if.cs_n_i = 1'b0; spi_if.sclk_i = 1'b0; spi_if.mosi_i = cmd[7];
    m_fa = 1'b1; push(1'b0); half();
    // command byte
    for (int i = 0; i < cmd_bits; i++) begin
      @(negedge clk);
      spi_if.sclk_i = 1'b1;
      if (i == 7) begin
        if (!w && c) begin
          m_cr = m_shadow; push(1'b1);
        end else begin
          phase_data = 1'b1;
          if (!w) begin
            if (idx < W/8) rbyte = m_cr[idx*8 +: 8];
            m_miso = rbyte[7]; push(1'b0);
          end
        end
      end
      half();
      @(negedge clk);
      spi_if.sclk_i = 1'b0;
      spi_if.mosi_i = (i < 7) ? cmd[6-i] : data[7];
      half();
    end
    // data phase (and any extra clocks)
    if (cmd_bits == 8) begin
      for (int j = 0; j < data_bits; j++) begin
        @(negedge clk);
        spi_if.sclk_i = 1'b1;
        rd = {rd[6:0], spi_if.miso_o};
        if (phase_data && j == 7) begin
          if (w) begin
            if (idx < W/8) m_shadow[idx*8 +: 8] = data;
            if (c) begin m_cr = m_shadow; push(1'b1); end
          end else begin
            m_miso = 1'b0; push(1'b0);
          end
        end
        half();
        @(negedge clk);
        spi_if.sclk_i = 1'b0;
        spi_if.mosi_i = data[7 - ((j + 1) % 8)];
        if (phase_data && !w && j < 7) begin
          m_miso = rbyte[6-j]; push(1'b0);
        end
        half();
      end
    end
    if (rst_mid) begin
      @(negedge clk);
      rstn = 1'b0;
      model_reset();
      #1;
      chk("rst_cr_immediate", cr, 64'h0);
      chk("rst_fa_immediate", W'(fa), 64'h0);
      chk("rst_strb_immediate", W'(strb), 64'h0);
      chk("rst_miso_immediate", W'(spi_if.miso_o), 64'h0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      // rest of the interrupted frame: must be ignored
      for (int j = 0; j < 4; j++) begin
        @(negedge clk); spi_if.sclk_i = 1'b1; spi_if.mosi_i = 1'b1; half();
        @(negedge clk); spi_if.sclk_i = 1'b0; half();
      end
    end
    // frame end
    @(negedge clk);
    spi_if.cs_n_i = 1'b1;
    m_fa = 1'b0; m_miso = 1'b0; push(1'b0);
    repeat (7) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rd;
    logic [7:0] c8;
    rstn = 1'b0;
    spi_if.cs_n_i = 1'b1; spi_if.sclk_i = 1'b0; spi_if.mosi_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_cr", cr, 64'h0);
    chk("reset_fa", W'(fa), 64'h0);
    chk("reset_state", W'(st), 64'h0);

    // 1: write+commit byte 0
    frame(8'hC0, 8'h5A, 8, 8, 1'b0, rd);
    chk("t1_cr", cr, 64'h0000_0000_0000_005A);
    chk("t1_strobes", W'(strb_seen), 64'd1);

    // 2: shadow-only write to byte 7, then commit-only
    frame(8'h87, 8'h80, 8, 8, 1'b0, rd);
    chk("t2_cr_before_commit", cr, 64'h0000_0000_0000_005A);
    chk("t2_strobes_before", W'(strb_seen), 64'd1);
    frame(8'h40, 8'h00, 8, 0, 1'b0, rd);
    chk("t2_cr_after_commit", cr, 64'h8000_0000_0000_005A);
    chk("t2_strobes_after", W'(strb_seen), 64'd2);

    // 3: abort after 5 data bits
    frame(8'hC2, 8'hFF, 8, 5, 1'b0, rd);
    chk("t3_cr", cr, 64'h8000_0000_0000_005A);
    chk("t3_strobes", W'(strb_seen), 64'd2);
    chk("t3_state_idle", W'(st), 64'h0);
    chk("t3_fa", W'(fa), 64'h0);

    // 4: readback of bytes 0 and 7
    frame(8'h00, 8'h00, 8, 8, 1'b0, rd);
    chk("t4_read_idx0", W'(rd), 64'h5A);
    frame(8'h07, 8'h00, 8, 8, 1'b0, rd);
    chk("t4_read_idx7", W'(rd), 64'h80);

    // 5: reset in the data phase, then a clean frame
    frame(8'hC1, 8'hA5, 8, 4, 1'b1, rd);
    chk("t5_cr_after_reset", cr, 64'h0);
    frame(8'hC0, 8'h3C, 8, 8, 1'b0, rd);
    chk("t5_cr_clean", cr, 64'h0000_0000_0000_003C);
    chk("t5_strobes", W'(strb_seen), 64'd3);

    // 6: out-of-range index write still commits; read returns 0
    frame(8'hC9, 8'hFF, 8, 8, 1'b0, rd);
    chk("t6_cr", cr, 64'h0000_0000_0000_003C);
    chk("t6_strobes", W'(strb_seen), 64'd4);
    frame(8'h09, 8'h00, 8, 8, 1'b0, rd);
    chk("t6_read_idx9", W'(rd), 64'h00);

    // extra byte after a write-commit, extra clocks after commit-only, partial cmd
    frame(8'hC1, 8'h33, 8, 16, 1'b0, rd);
    chk("x_extra_byte_cr", cr, 64'h0000_0000_0000_333C);
    chk("x_extra_byte_strobes", W'(strb_seen), 64'd5);
    frame(8'h40, 8'hFF, 8, 8, 1'b0, rd);
    chk("x_commit_extra_cr", cr, 64'h0000_0000_0000_333C);
    chk("x_commit_extra_strobes", W'(strb_seen), 64'd6);
    frame(8'hC0, 8'hEE, 3, 0, 1'b0, rd);
    chk("x_partial_cmd_cr", cr, 64'h0000_0000_0000_333C);
    chk("x_partial_cmd_strobes", W'(strb_seen), 64'd6);

    // fill bytes 2..7 in the shadow, then commit them all at once
    for (int k = 2; k < 8; k++) begin
      c8 = 8'h80 | 8'(k);
      frame(c8, 8'h10 + 8'(k), 8, 8, 1'b0, rd);
    end
    chk("x_shadow_fill_cr", cr, 64'h0000_0000_0000_333C);
    frame(8'h40, 8'h00, 8, 0, 1'b0, rd);
    chk("x_full_commit_cr", cr, 64'h1716_1514_1312_333C);
    chk("x_full_commit_strobes", W'(strb_seen), 64'd7);
    frame(8'h05, 8'h00, 8, 8, 1'b0, rd);
    chk("x_read_idx5", W'(rd), 64'h15);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: stimulus still running at cycle %0d, required to have ended", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
